// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port memory between the RV32I fetch (IF)
// and load/store (LS) ports. Only one transaction is outstanding at a time.
// LS has fixed priority, a starvation counter bounds how long IF can be held
// off, and a response timeout aborts transactions to a dead memory.
//
// Handshake: a port request is sampled while the arbiter is IDLE; *_gnt pulses
// one cycle after the request is latched, and the requester may change its
// inputs from then on. mem_req stays high with mem_* held stable until
// mem_ready is seen. Reads then wait for mem_rvalid. Every granted request ends
// with exactly one rvalid pulse to its owner: either the data, a store
// completion, or rdata=0 together with bus_err when the timeout fires.
module rv32_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err,
    output logic [1:0]          dbg_state,
    output logic [3:0]          dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_LS     = 1'b1;

    state_t     state;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic       owner;
    logic       sel_ls;
    logic       sel_if;
    logic       tmo_expired;

    // Grant selection: LS wins unless IF has been passed over MAX_WAIT times.
    always_comb begin
        sel_ls = 1'b0;
        sel_if = 1'b0;
        if (ls_req && (starve_cnt < MAX_WAIT_C)) begin
            sel_ls = 1'b1;
        end else if (if_req) begin
            sel_if = 1'b1;
        end else if (ls_req) begin
            sel_ls = 1'b1;
        end
    end

    // Expiry is judged on the registered count so a completion in the same cycle wins.
    assign tmo_expired    = (tmo_cnt == TIMEOUT_C);
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    // Arbiter FSM with all outputs registered; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            owner      <= OWN_IF;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_ls) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ls_we;
                        mem_be    <= ls_be;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        owner     <= OWN_LS;
                        ls_gnt    <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= BUSY;
                        if (if_req) begin
                            if (starve_cnt < MAX_WAIT_C) starve_cnt <= starve_cnt + 4'd1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (sel_if) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= '1;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        owner      <= OWN_IF;
                        if_gnt     <= 1'b1;
                        tmo_cnt    <= '0;
                        starve_cnt <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        // Saturate so the count cannot wrap while crossing into RESP.
                        if (!tmo_expired) tmo_cnt <= tmo_cnt + 8'd1;
                        if (mem_we) begin
                            ls_rvalid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (tmo_expired) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (owner == OWN_LS) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_LS) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        state <= IDLE;
                    end else if (tmo_expired) begin
                        bus_err <= 1'b1;
                        if (owner == OWN_LS) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter (MAX_WAIT=4, TIMEOUT=255).
// Cycle k is the interval after rising edge k; outputs are sampled 1 ns after
// the edge and inputs are changed at the same point for the next edge.
module tb_rv32_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_starve_cnt;

    int total;
    int bad;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_BUSY = 32'd1;
    localparam logic [31:0] ST_RESP = 32'd2;

    rv32_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit exceeded");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] exp_if_gnt;
        int         exp_starve [10];
        int         n;

        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_be      = '0;
        ls_addr    = '0;
        ls_wdata   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_state", 32'(dbg_state), ST_IDLE);
        check("rst_starve", 32'(dbg_starve_cnt), 32'd0);

        // Zero-wait fetch
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        tick();
        check("f_if_gnt", 32'(if_gnt), 32'd1);
        check("f_mem_req", 32'(mem_req), 32'd1);
        check("f_mem_addr", mem_addr, 32'h0000_0100);
        check("f_mem_we", 32'(mem_we), 32'd0);
        check("f_mem_be", 32'(mem_be), 32'hF);
        check("f_state1", 32'(dbg_state), ST_BUSY);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("f_if_gnt_pulse", 32'(if_gnt), 32'd0);
        check("f_mem_req_drop", 32'(mem_req), 32'd0);
        check("f_state2", 32'(dbg_state), ST_RESP);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0050_0093;
        tick();
        check("f_if_rvalid", 32'(if_rvalid), 32'd1);
        check("f_if_rdata", if_rdata, 32'h0050_0093);
        check("f_ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("f_state3", 32'(dbg_state), ST_IDLE);
        mem_rvalid = 1'b0;
        tick();
        check("f_if_rvalid_pulse", 32'(if_rvalid), 32'd0);
        check("f_if_rdata_hold", if_rdata, 32'h0050_0093);

        // Store with three wait cycles; requester inputs scrambled after grant
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_be    = 4'h3;
        ls_addr  = 32'h0000_2000;
        ls_wdata = 32'hDEAD_BEEF;
        tick();
        check("s_ls_gnt", 32'(ls_gnt), 32'd1);
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_be    = 4'hC;
        ls_addr  = 32'hFFFF_FFF0;
        ls_wdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            check("s_mem_req_hold", 32'(mem_req), 32'd1);
            check("s_mem_we_hold", 32'(mem_we), 32'd1);
            check("s_mem_be_hold", 32'(mem_be), 32'h3);
            check("s_mem_addr_hold", mem_addr, 32'h0000_2000);
            check("s_mem_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
            check("s_state_busy", 32'(dbg_state), ST_BUSY);
            check("s_no_early_rvalid", 32'(ls_rvalid), 32'd0);
            if (c == 2) mem_ready = 1'b1;
            tick();
        end
        check("s_mem_req_drop", 32'(mem_req), 32'd0);
        check("s_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("s_if_rvalid", 32'(if_rvalid), 32'd0);
        check("s_state_idle", 32'(dbg_state), ST_IDLE);
        mem_ready = 1'b0;
        tick();
        check("s_ls_rvalid_pulse", 32'(ls_rvalid), 32'd0);
        check("s_state_idle2", 32'(dbg_state), ST_IDLE);

        // Both ports requesting continuously: LS x4, IF, LS x4, IF
        exp_if_gnt = 10'b10_0001_0000;
        exp_starve = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_be   = 4'hF;
        ls_addr = 32'h0000_3000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a_if_gnt", 32'(if_gnt), 32'(exp_if_gnt[i]));
            check("a_ls_gnt", 32'(ls_gnt), 32'(!exp_if_gnt[i]));
            check("a_starve", 32'(dbg_starve_cnt), 32'(exp_starve[i]));
            check("a_mem_addr", mem_addr, exp_if_gnt[i] ? 32'h0000_0200 : 32'h0000_3000);
            mem_ready = 1'b1;
            tick();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_1000 + 32'(i);
            tick();
            mem_rvalid = 1'b0;
            check("a_if_rvalid", 32'(if_rvalid), 32'(exp_if_gnt[i]));
            check("a_ls_rvalid", 32'(ls_rvalid), 32'(!exp_if_gnt[i]));
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        check("a_last_if_rdata", if_rdata, 32'h0000_1009);
        check("a_last_ls_rdata", ls_rdata, 32'h0000_1008);
        tick();
        check("a_idle_after", 32'(dbg_state), ST_IDLE);

        // Read accepted but never answered: timeout abort in cycle 257
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_4000;
        tick();
        check("t_ls_gnt", 32'(ls_gnt), 32'd1);
        ls_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n = 2;
        while (!bus_err && n < 300) begin
            tick();
            n++;
        end
        check("t_abort_cycle", 32'(n), 32'd257);
        check("t_bus_err", 32'(bus_err), 32'd1);
        check("t_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("t_ls_rdata_zero", ls_rdata, 32'd0);
        check("t_if_rvalid", 32'(if_rvalid), 32'd0);
        check("t_mem_req", 32'(mem_req), 32'd0);
        check("t_state_idle", 32'(dbg_state), ST_IDLE);
        tick();
        check("t_bus_err_pulse", 32'(bus_err), 32'd0);
        // Next request after the abort is served normally
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        tick();
        check("t_next_if_gnt", 32'(if_gnt), 32'd1);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
        tick();
        mem_rvalid = 1'b0;
        check("t_next_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t_next_if_rdata", if_rdata, 32'hCAFE_0001);
        check("t_next_bus_err", 32'(bus_err), 32'd0);

        // Asynchronous reset while BUSY
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_5000;
        tick();
        ls_req = 1'b0;
        check("r_mem_req_before", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("r_mem_req_async", 32'(mem_req), 32'd0);
        check("r_state_async", 32'(dbg_state), ST_IDLE);
        check("r_ls_rdata_clear", ls_rdata, 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0BAD;
        tick();
        check("r_no_ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("r_no_if_rvalid", 32'(if_rvalid), 32'd0);
        check("r_ls_rdata_stale", ls_rdata, 32'd0);
        check("r_mem_req_idle", 32'(mem_req), 32'd0);
        check("r_state_idle", 32'(dbg_state), ST_IDLE);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        tick();

        // Load answered in the same cycle the timeout count reaches 255
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_6000;
        tick();
        check("e_ls_gnt", 32'(ls_gnt), 32'd1);
        ls_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (254) tick();
        check("e_state_resp", 32'(dbg_state), ST_RESP);
        check("e_no_err_yet", 32'(bus_err), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check("e_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("e_bus_err", 32'(bus_err), 32'd0);
        check("e_ls_rdata", ls_rdata, 32'h1234_5678);
        check("e_state_idle", 32'(dbg_state), ST_IDLE);
        tick();
        check("e_ls_rvalid_pulse", 32'(ls_rvalid), 32'd0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
